adc_serial_rx: RTL and testbench

- Serial front-end for the 12-bit ADC that digitises the LT5534 detector output (ADCS7476-style framing: 4 leading zeros, then 12 data bits MSB-first).
- Drives `adc_cs` and `adc_clk` and shifts in `adc_so`.
- Presents each conversion as a parallel 12-bit sample with a one-cycle valid strobe.
- Sits between the detector pins and the loctag trigger/detection logic.

---
 rtl/adc_serial_rx.sv | 117 +++++++++++
 tb/tb_adc_serial_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_rx.sv
// rtl/adc_serial_rx.sv - ADCS7476-style serial receiver: drives CS/SCLK, shifts in 16-bit frames, emits 12-bit samples
module adc_serial_rx #(
    parameter int HALF_DIV     = 2,
    parameter int QUIET_CYCLES = 4,
    parameter int FRAME_BITS   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic        adc_cs,
    output logic        adc_clk,
    input  logic        adc_so,
    output logic [11:0] sample_data,
    output logic        sample_valid,
    output logic        lead_err,
    output logic [15:0] sample_count,
    output logic        busy
);

    localparam int PW = (HALF_DIV > 1) ? $clog2(2 * HALF_DIV) : 1;
    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        QUIET,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [PW-1:0] ph;
    logic [3:0]    bit_idx;
    logic [QW-1:0] qcnt;
    logic [15:0]   shreg;
    logic [15:0]   shift_next;

    // The final bit lands on the same edge that publishes the sample.
    assign shift_next = {shreg[14:0], adc_so};

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ph           <= '0;
            bit_idx      <= '0;
            qcnt         <= '0;
            shreg        <= '0;
            adc_cs       <= 1'b1;
            adc_clk      <= 1'b1;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            lead_err     <= 1'b0;
            sample_count <= '0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    adc_cs  <= 1'b1;
                    adc_clk <= 1'b1;
                    busy    <= 1'b0;
                    if (en) begin
                        state <= QUIET;
                        qcnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                QUIET: begin
                    if (qcnt == QW'(QUIET_CYCLES - 1)) begin
                        state   <= SHIFT;
                        adc_cs  <= 1'b0;
                        adc_clk <= 1'b0;
                        ph      <= '0;
                        bit_idx <= '0;
                    end else begin
                        qcnt <= qcnt + QW'(1);
                    end
                end
                SHIFT: begin
                    if (ph == PW'(2 * HALF_DIV - 1)) begin
                        shreg <= shift_next;
                        if (bit_idx == 4'(FRAME_BITS - 1)) begin
                            state        <= DONE;
                            adc_cs       <= 1'b1;
                            adc_clk      <= 1'b1;
                            sample_data  <= shift_next[11:0];
                            lead_err     <= |shift_next[15:12];
                            sample_valid <= 1'b1;
                            sample_count <= sample_count + 16'd1;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            ph      <= '0;
                            adc_clk <= 1'b0;
                        end
                    end else begin
                        ph <= ph + PW'(1);
                        if (ph == PW'(HALF_DIV - 1)) begin
                            adc_clk <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (en) begin
                        state <= QUIET;
                        qcnt  <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_rx.sv
// tb/tb_adc_serial_rx.sv - bench for adc_serial_rx: default and HALF_DIV=1/QUIET_CYCLES=1 instances
module tb_adc_serial_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  en;
    logic [1:0]  rst;
    logic [15:0] wtab [2][8];
    int total = 0;
    int bad   = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int H  = (gi == 0) ? 2 : 1;
        localparam int Q  = (gi == 0) ? 4 : 1;
        localparam int SH = 32 * H;

        logic        cs, ck, so, busy, valid, lead;
        logic [11:0] data;
        logic [15:0] cnt;
        logic [32:0] av;

        adc_serial_rx #(.HALF_DIV(H), .QUIET_CYCLES(Q), .FRAME_BITS(16)) u_dut (
            .clk(clk), .reset(rst[gi]), .en(en[gi]),
            .adc_cs(cs), .adc_clk(ck), .adc_so(so),
            .sample_data(data), .sample_valid(valid), .lead_err(lead),
            .sample_count(cnt), .busy(busy)
        );

        assign av = {cs, ck, busy, valid, data, lead, cnt};

        // ADC pin model: first bit on CS fall, next bit on each SCLK fall.
        logic [15:0] cur  = 16'h0;
        logic [2:0]  aidx = 3'd0;
        int          falls = 0;
        logic        pcs = 1'b1, pck = 1'b1;
        initial so = 1'b1;
        always @(negedge clk) begin
            if (!cs && pcs) begin
                cur   = wtab[gi][aidx];
                aidx  = aidx + 3'd1;
                falls = 0;
            end
            if (!cs && !ck && pck && falls < 16) begin
                so    = cur[15 - falls];
                falls = falls + 1;
            end else if (cs) begin
                so = 1'b1;
            end
            pcs = cs;
            pck = ck;
        end

        // Frame-time model: t counts cycles since the frame began.
        bit          run = 1'b0;
        int          t = 0;
        logic [15:0] mc = 16'h0, mw = 16'h0;
        logic [11:0] md = 12'h0;
        logic        ml = 1'b0;
        logic [2:0]  midx = 3'd0;
        logic        sh;
        logic [32:0] ev = {1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 1'b0, 16'h0};
        always @(posedge clk) begin
            if (rst[gi]) begin
                run = 1'b0; t = 0; mc = 16'h0; md = 12'h0; ml = 1'b0;
            end else if (!run) begin
                if (en[gi]) begin run = 1'b1; t = 0; end
            end else if (t == Q + SH) begin
                if (en[gi]) t = 0;
                else run = 1'b0;
            end else begin
                t = t + 1;
                if (t == Q) begin mw = wtab[gi][midx]; midx = midx + 3'd1; end
                if (t == Q + SH) begin mc = mc + 16'd1; md = mw[11:0]; ml = |mw[15:12]; end
            end
            sh = run && t >= Q && t < Q + SH;
            ev = {!sh, sh ? ((t - Q) % (2 * H) >= H) : 1'b1, run, run && t == Q + SH, md, ml, mc};
        end
    end

    task automatic cmp(input string name, input logic [32:0] a, input logic [32:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, a, e);
        end
    endtask

    task automatic chk(input string name, input int a, input int e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, a, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cmp("model0", g[0].av, g[0].ev);
            cmp("model1", g[1].av, g[1].ev);
        end
    endtask

    int n, k, viol, lows, bw, run_len, cslow, strobes;
    bit prev;
    int vt [4];
    int vd [4];
    int vl [4];

    initial begin
        rst = 2'b11;
        en  = 2'b00;
        wtab[0][0] = 16'h0ABC; wtab[0][1] = 16'h0000; wtab[0][2] = 16'h0FFF; wtab[0][3] = 16'h0800;
        wtab[0][4] = 16'h0001; wtab[0][5] = 16'h5123; wtab[0][6] = 16'h0FA5; wtab[0][7] = 16'h0333;
        wtab[1][0] = 16'h0123; wtab[1][1] = 16'h0456; wtab[1][2] = 16'hF789; wtab[1][3] = 16'h0ACE;
        for (int i = 4; i < 8; i++) wtab[1][i] = 16'h0000;

        tick(3);
        rst[0] = 1'b0;

        viol = 0;
        repeat (100) begin
            tick(1);
            if (g[0].cs !== 1'b1 || g[0].ck !== 1'b1 || g[0].busy !== 1'b0 ||
                g[0].valid !== 1'b0 || g[0].cnt !== 16'h0) viol++;
        end
        chk("idle_hold", viol, 0);

        // single-cycle en pulse, one full frame
        en[0] = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
            if (n == 1) en[0] = 1'b0;
        end while (g[0].cs !== 1'b0 && n < 50);
        chk("cs_fall_delay", n, 5);

        lows = 0; bw = 0; run_len = 0; prev = 1'b1; cslow = 0; n = 0;
        while (g[0].valid !== 1'b1 && n < 200) begin
            if (g[0].cs == 1'b0) cslow++;
            if (g[0].ck == 1'b0) begin
                run_len++;
                if (prev) lows++;
            end else begin
                if (!prev && run_len != 2) bw++;
                run_len = 0;
            end
            prev = g[0].ck;
            tick(1);
            n++;
        end
        chk("strobe_seen", int'(g[0].valid), 1);
        chk("sclk_low_pulses", lows, 16);
        chk("sclk_low_width", bw, 0);
        chk("cs_low_cycles", cslow, 64);
        chk("data_abc", int'(g[0].data), 12'hABC);
        chk("lead_abc", int'(g[0].lead), 0);
        chk("count_1", int'(g[0].cnt), 1);
        tick(1);
        chk("strobe_width", int'(g[0].valid), 0);
        tick(20);
        chk("idle_after_pulse", int'({g[0].cs, g[0].busy}), 2);

        // continuous conversions after a fresh reset
        rst[0] = 1'b1;
        tick(1);
        rst[0] = 1'b0;
        en[0] = 1'b1;
        k = 0; n = 0;
        while (k < 4 && n < 400) begin
            tick(1);
            n++;
            if (g[0].valid) begin
                vt[k] = n; vd[k] = int'(g[0].data); k++;
                if (k == 4) en[0] = 1'b0;
            end
        end
        chk("cont_strobes", k, 4);
        chk("cont_d0", vd[0], 12'h000);
        chk("cont_d1", vd[1], 12'hFFF);
        chk("cont_d2", vd[2], 12'h800);
        chk("cont_d3", vd[3], 12'h001);
        for (int i = 1; i < 4; i++) chk("cont_period", vt[i] - vt[i-1], 69);
        chk("cont_count", int'(g[0].cnt), 4);
        tick(5);
        chk("cont_idle", int'(g[0].busy), 0);

        // nonzero leading nibble
        en[0] = 1'b1;
        tick(1);
        en[0] = 1'b0;
        n = 0;
        while (g[0].valid !== 1'b1 && n < 200) begin tick(1); n++; end
        chk("lead_data", int'(g[0].data), 12'h123);
        chk("lead_flag", int'(g[0].lead), 1);
        chk("lead_count", int'(g[0].cnt), 5);

        // en dropped at s=20: frame still completes
        en[0] = 1'b1;
        n = 0;
        while (g[0].cs !== 1'b0 && n < 50) begin tick(1); n++; end
        tick(20);
        en[0] = 1'b0;
        strobes = 0; vd[0] = 0;
        repeat (150) begin
            tick(1);
            if (g[0].valid) begin strobes++; vd[0] = int'(g[0].data); end
        end
        chk("drop_strobes", strobes, 1);
        chk("drop_data", vd[0], 12'hFA5);
        chk("drop_idle", int'({g[0].cs, g[0].busy}), 2);

        // reset at s=10 discards the frame
        en[0] = 1'b1;
        n = 0;
        while (g[0].cs !== 1'b0 && n < 50) begin tick(1); n++; end
        tick(10);
        rst[0] = 1'b1;
        en[0] = 1'b0;
        tick(1);
        chk("rst_outputs", int'({g[0].cs, g[0].ck, g[0].valid, g[0].busy}), 4'b1100);
        chk("rst_count", int'(g[0].cnt), 0);
        rst[0] = 1'b0;
        tick(80);
        chk("rst_no_strobe_count", int'(g[0].cnt), 0);

        // HALF_DIV=1, QUIET_CYCLES=1 instance
        rst[1] = 1'b0;
        tick(2);
        en[1] = 1'b1;
        k = 0; n = 0;
        while (k < 3 && n < 300) begin
            tick(1);
            n++;
            if (g[1].valid) begin
                vt[k] = n; vd[k] = int'(g[1].data); vl[k] = int'(g[1].lead); k++;
                if (k == 3) en[1] = 1'b0;
            end
        end
        chk("fast_strobes", k, 3);
        chk("fast_period01", vt[1] - vt[0], 34);
        chk("fast_period12", vt[2] - vt[1], 34);
        chk("fast_d0", vd[0], 12'h123);
        chk("fast_d1", vd[1], 12'h456);
        chk("fast_d2", vd[2], 12'h789);
        chk("fast_lead2", vl[2], 1);
        chk("fast_count", int'(g[1].cnt), 3);

        tick(3);
        force g[1].u_dut.sample_count = 16'hFFFF;
        g[1].mc = 16'hFFFF;
        tick(1);
        release g[1].u_dut.sample_count;
        tick(1);
        en[1] = 1'b1;
        tick(1);
        en[1] = 1'b0;
        n = 0;
        while (g[1].valid !== 1'b1 && n < 100) begin tick(1); n++; end
        chk("wrap_strobe", int'(g[1].valid), 1);
        chk("wrap_count", int'(g[1].cnt), 0);
        chk("wrap_data", int'(g[1].data), 12'hACE);
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
